r_cpu_mc: RTL
=============

Name: r_cpu_mc

Overview:
- Multi-cycle, parametrised successor of the single-cycle R-type CPU.
- Executes R-type ALU instructions plus ADDI and HALT through an explicit IF/ID/EX/WB state machine.
- Parametrised register width and instruction-memory depth; writable instruction memory, run/stall control, retire strobe and debug register read port.
- Top-level execution core for the CPU labs; the bench drives it directly.

Parameters:
- DATA_W, 32, register/ALU width; legal 16..64; instruction word fixed at 32 bits.
- IMEM_AW, 6, instruction-memory word-address width (depth 2**IMEM_AW).
- RESET_PC, 0, PC value after reset; word-aligned.

Ports:
- clka  in  1  clock; all state changes on rising edge.
- rsta  in  1  asynchronous active-low reset.
- run  in  1  1 = FSM advances; 0 = hold current state, all registers frozen.
- imem_we  in  1  instruction-memory write strobe.
- imem_waddr  in  IMEM_AW  word address for imem write.
- imem_wdata  in  32  instruction word to write.
- dbg_raddr  in  5  debug register index.
- dbg_rdata  out  DATA_W  combinational read of register dbg_raddr.
- pc  out  32  current PC (byte address).
- douta  out  DATA_W  registered ALU result of the last EX.
- ofa  out  1  registered signed-overflow flag.
- zfa  out  1  registered zero flag.
- retire  out  1  one-cycle pulse in WB of each completed instruction.
- halted  out  1  high while in HALT.

Behaviour:
- Reset (async, rsta=0):
  - State=IF, pc=RESET_PC.
  - douta=0, ofa=0, zfa=0, retire=0, halted=0, IR=0.
  - All 32 registers cleared.
  - imem contents are not reset.
- FSM:
  - IF -> ID -> EX -> WB -> IF; 4 clocks per instruction when run=1.
  - HALT is terminal; only reset leaves it.
- IF: IR <= imem[pc[IMEM_AW+1:2]] (synchronous read).
- ID:
  - A <= R[rs], B <= R[rt].
  - Decode op=IR[31:26]. op=6'b111111 -> next state HALT instead of EX.
- EX:
  - Compute result, load douta, ofa, zfa. zfa = (result==0).
  - R-type (op=0) by func:
    - 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR.
    - 101010 SLT: signed, result 1/0.
    - 000000 SLL by shamt; 000010 SRL by shamt. Shift amount is taken mod DATA_W.
  - ADDI (op=001000): A + sign-extend(IR[15:0]) to DATA_W.
  - ofa = signed overflow for ADD/SUB/ADDI only, else 0.
  - Unknown func/op: result=0, no write-back (NOP); flags still updated.
  - Arithmetic wraps modulo 2**DATA_W. An overflowing result is still written.
- WB:
  - Write destination if enabled: R-type -> rd, ADDI -> rt.
  - Writes to R0 are dropped; R0 always reads 0.
  - pc <= pc+4, wrapping at 4*2**IMEM_AW back to 0.
  - retire=1 this cycle only.
- HALT: halted=1; pc, registers and flags hold. retire is not pulsed for HALT.
- run=0 in any state:
  - No state, PC, register or flag change.
  - retire is forced 0 while run=0; a stalled WB pulses once when run returns.
- imem writes:
  - Accepted every cycle regardless of state or run.
  - A write and an IF read of the same address in the same cycle: IF gets the old word.
- dbg_rdata: combinational. A WB write to the same register is visible after the edge.
- Reset asserted mid-instruction: the in-flight write-back is aborted.

Decomposition:
- Package r_cpu_pkg:
  - Opcode constants OP_RTYPE, OP_ADDI, OP_HALT.
  - Func constants for the nine ALU operations.
  - FSM state encoding: IF, ID, EX, WB, HALT.
  - Internal ALU-op enum.
- Sub-module r_cpu_regfile, parametrised by DATA_W:
  - 32 registers, 2 sync-captured read ports plus the debug combinational port.
  - 1 write port, R0 hardwired to zero, async active-low clear.
- The ALU stays inline in r_cpu_mc.

Test Plan:
- Basic add: load ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; HALT. Run -> retire pulses at cycles 4, 8, 12; douta=12; dbg r3=12; halted=1 by cycle 14; pc=0x0C held.
- Overflow/zero: ADDI r1,r0,0x7FFF; SLL r1,r1,16 -> 0x7FFF0000. ADD r2,r1,r1 -> douta=0xFFFE0000, ofa=1, r2 written. SUB r3,r1,r1 -> douta=0, zfa=1, ofa=0.
- R0 and negatives:
  - ADDI r0,r0,9 -> dbg r0 stays 0.
  - ADDI r4,r0,-1 -> r4=0xFFFFFFFF.
  - SLT r5,r4,r0 -> 1.
  - SRL r6,r4,28 -> 0xF.
- Stall: drop run for 10 cycles during EX of an ADD -> no retire, pc and douta frozen. Raise run -> the instruction completes exactly 2 cycles later.
- PC wrap with IMEM_AW=2: four ADDI instructions, no HALT -> pc sequence 0,4,8,C,0; first instruction re-executes.
- Reset mid-WB: assert rsta during WB of ADDI r7,r0,3 -> r7=0, pc=RESET_PC, outputs 0. Same-address imem write during IF -> fetched word is the old value.

Source files
------------

// File: rtl/r_cpu_pkg.sv
// Shared encodings for the multi-cycle R-type CPU: opcodes, function codes,
// FSM states and the internal ALU operation selector.
package r_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    typedef enum logic [2:0] {ST_IF, ST_ID, ST_EX, ST_WB, ST_HALT} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_NOP
    } alu_op_t;

    // ADDI reuses the adder; anything unrecognised becomes a non-writing NOP.
    function automatic alu_op_t decode_alu(input logic [5:0] op, input logic [5:0] fn);
        alu_op_t r;
        r = ALU_NOP;
        if (op == OP_ADDI) begin
            r = ALU_ADD;
        end else if (op == OP_RTYPE) begin
            case (fn)
                FN_ADD:  r = ALU_ADD;
                FN_SUB:  r = ALU_SUB;
                FN_AND:  r = ALU_AND;
                FN_OR:   r = ALU_OR;
                FN_XOR:  r = ALU_XOR;
                FN_NOR:  r = ALU_NOR;
                FN_SLT:  r = ALU_SLT;
                FN_SLL:  r = ALU_SLL;
                FN_SRL:  r = ALU_SRL;
                default: r = ALU_NOP;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/r_cpu_regfile.sv
// 32-entry register file: two operand ports captured on rd_en, one write
// port, a combinational debug port; R0 is never written so it reads zero.
module r_cpu_regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [4:0]        dbg_ra,
    output logic [DATA_W-1:0] dbg_rd
);

    logic [DATA_W-1:0] regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
            rd1 <= '0;
            rd2 <= '0;
        end else begin
            if (we && (wa != 5'd0)) regs[wa] <= wd;
            if (rd_en) begin
                rd1 <= regs[ra1];
                rd2 <= regs[ra2];
            end
        end
    end

    always_comb dbg_rd = regs[dbg_ra];

endmodule

// File: rtl/r_cpu_mc.sv
// Multi-cycle CPU core: IF/ID/EX/WB sequencer with inline ALU, writable
// instruction memory, run/stall control and a debug register port.
module r_cpu_mc
    import r_cpu_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          IMEM_AW  = 6,
    parameter logic [31:0] RESET_PC = '0
) (
    input  logic               clka,
    input  logic               rsta,
    input  logic               run,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [31:0]        imem_wdata,
    input  logic [4:0]         dbg_raddr,
    output logic [DATA_W-1:0]  dbg_rdata,
    output logic [31:0]        pc,
    output logic [DATA_W-1:0]  douta,
    output logic               ofa,
    output logic               zfa,
    output logic               retire,
    output logic               halted
);

    state_t state, state_nxt;
    logic [31:0] imem [2**IMEM_AW];
    logic [31:0] ir;
    logic [DATA_W-1:0] a_q, b_q, opb, imm_ext, res;
    logic ir_ld, ab_ld, ex_go, wb_go, wb_en, ovf, wr_ok, is_addi;
    logic [6:0] sh;
    logic [4:0] wb_dst;
    logic [IMEM_AW-1:0] pc_word_nxt;
    alu_op_t alu_op;

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) state <= ST_IF;
        else       state <= state_nxt;
    end

    // Every step is gated by run, so a stalled FSM neither advances nor strobes.
    always_comb begin
        state_nxt = state;
        ir_ld     = 1'b0;
        ab_ld     = 1'b0;
        ex_go     = 1'b0;
        wb_go     = 1'b0;
        retire    = 1'b0;
        halted    = 1'b0;
        case (state)
            ST_IF: if (run) begin
                ir_ld     = 1'b1;
                state_nxt = ST_ID;
            end
            ST_ID: if (run) begin
                ab_ld     = 1'b1;
                state_nxt = (ir[31:26] == OP_HALT) ? ST_HALT : ST_EX;
            end
            ST_EX: if (run) begin
                ex_go     = 1'b1;
                state_nxt = ST_WB;
            end
            ST_WB: if (run) begin
                wb_go     = 1'b1;
                retire    = 1'b1;
                state_nxt = ST_IF;
            end
            ST_HALT: halted = 1'b1;
            default: state_nxt = ST_IF;
        endcase
    end

    always_comb begin
        alu_op  = decode_alu(ir[31:26], ir[5:0]);
        is_addi = (ir[31:26] == OP_ADDI);
        imm_ext = {{(DATA_W-16){ir[15]}}, ir[15:0]};
        opb     = is_addi ? imm_ext : b_q;
        sh      = 7'(int'(ir[10:6]) % DATA_W);
        res     = '0;
        ovf     = 1'b0;
        wr_ok   = (alu_op != ALU_NOP);
        case (alu_op)
            ALU_ADD: begin
                res = a_q + opb;
                ovf = (a_q[DATA_W-1] == opb[DATA_W-1]) && (res[DATA_W-1] != a_q[DATA_W-1]);
            end
            ALU_SUB: begin
                res = a_q - b_q;
                ovf = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (res[DATA_W-1] != a_q[DATA_W-1]);
            end
            ALU_AND: res = a_q & b_q;
            ALU_OR:  res = a_q | b_q;
            ALU_XOR: res = a_q ^ b_q;
            ALU_NOR: res = ~(a_q | b_q);
            ALU_SLT: res[0] = ($signed(a_q) < $signed(b_q));
            ALU_SLL: res = b_q << sh;
            ALU_SRL: res = b_q >> sh;
            default: res = '0;
        endcase
        wb_dst      = is_addi ? ir[20:16] : ir[15:11];
        pc_word_nxt = pc[IMEM_AW+1:2] + IMEM_AW'(1);
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            pc    <= RESET_PC;
            ir    <= '0;
            douta <= '0;
            ofa   <= 1'b0;
            zfa   <= 1'b0;
            wb_en <= 1'b0;
        end else begin
            if (ir_ld) ir <= imem[pc[IMEM_AW+1:2]];
            if (ex_go) begin
                douta <= res;
                ofa   <= ovf;
                zfa   <= (res == '0);
                wb_en <= wr_ok;
            end
            if (wb_go) pc <= 32'({pc_word_nxt, 2'b00});
        end
    end

    always_ff @(posedge clka) begin
        if (imem_we) imem[imem_waddr] <= imem_wdata;
    end

    r_cpu_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk    (clka),
        .rst_n  (rsta),
        .rd_en  (ab_ld),
        .ra1    (ir[25:21]),
        .ra2    (ir[20:16]),
        .rd1    (a_q),
        .rd2    (b_q),
        .we     (wb_go && wb_en),
        .wa     (wb_dst),
        .wd     (douta),
        .dbg_ra (dbg_raddr),
        .dbg_rd (dbg_rdata)
    );

endmodule
